// File: rtl/path_stack_replay.sv
// Records the solver's forward steps as a direction stack and replays the
// surviving path from start to goal, one direction per clock, on request.
module path_stack_replay #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [1:0]  dir,
  input  logic        clear,
  input  logic        run,
  output logic        move,
  output logic [1:0]  move_dir,
  output logic        done,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  typedef enum logic [1:0] {RECORD, REPLAY, DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [AW:0] sp_q, sp_d;
  logic [AW:0] rp_q, rp_d;
  logic        move_q, move_d;
  logic [1:0]  move_dir_q, move_dir_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;

  logic [1:0]    mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [1:0]    mem_wdata;
  logic [AW:0]   sp_dec;

  assign sp_dec = sp_q - ONE_W;

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rp_d       = rp_q;
    move_d     = move_q;
    move_dir_d = move_dir_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = sp_q[AW-1:0];
    mem_wdata  = dir;

    if (clear) begin
      state_d    = RECORD;
      sp_d       = '0;
      rp_d       = '0;
      move_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        REPLAY: begin
          if (rp_q < sp_q) begin
            move_dir_d = mem[rp_q[AW-1:0]];
            rp_d       = rp_q + ONE_W;
          end else begin
            move_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        default: begin
          // A run request wins over push/pop and restarts from mem[0].
          if (run) begin
            if (sp_q != '0) begin
              state_d    = REPLAY;
              move_d     = 1'b1;
              move_dir_d = mem[0];
              rp_d       = ONE_W;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else if (state_q == RECORD) begin
            if (push && pop && sp_q != '0) begin
              mem_we    = 1'b1;
              mem_waddr = sp_dec[AW-1:0];
            end else if (push) begin
              if (sp_q != DEPTH_W) begin
                mem_we = 1'b1;
                sp_d   = sp_q + ONE_W;
              end else begin
                overflow_d = 1'b1;
              end
            end else if (pop && sp_q != '0) begin
              sp_d = sp_dec;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RECORD;
      sp_q       <= '0;
      rp_q       <= '0;
      move_q     <= 1'b0;
      move_dir_q <= 2'd0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rp_q       <= rp_d;
      move_q     <= move_d;
      move_dir_q <= move_dir_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Path storage needs no reset; sp bounds which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign move     = move_q;
  assign move_dir = move_dir_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign count    = sp_q;
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == DEPTH_W);

endmodule

// File: tb/tb_path_stack_replay.sv
// Bench for path_stack_replay: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_path_stack_replay;

  localparam int DEPTH = 8;
  localparam int M_REC = 0;
  localparam int M_REP = 1;
  localparam int M_DONE = 2;

  logic       clk, rst, push, pop, clear, run;
  logic [1:0] dir;
  logic       move, done, empty, full, overflow;
  logic [1:0] move_dir;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Reference model: the stored path and the remaining replay as queues.
  int stack_q[$];
  int replay_q[$];
  int m_mode, m_move, m_dir, m_done, m_ovf;

  path_stack_replay #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dir(dir),
    .clear(clear), .run(run), .move(move), .move_dir(move_dir),
    .done(done), .count(count), .empty(empty), .full(full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pu, input logic po, input logic [1:0] d,
                               input logic ru, input logic cl);
    push = pu; pop = po; dir = d; run = ru; clear = cl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_q.delete(); replay_q.delete();
      m_mode = M_REC; m_move = 0; m_dir = 0; m_done = 0; m_ovf = 0;
    end else if (clear) begin
      stack_q.delete(); replay_q.delete();
      m_mode = M_REC; m_move = 0; m_done = 0; m_ovf = 0;
    end else if (m_mode == M_REP) begin
      if (replay_q.size() > 0) m_dir = replay_q.pop_front();
      else begin m_move = 0; m_done = 1; m_mode = M_DONE; end
    end else if (run) begin
      if (stack_q.size() > 0) begin
        replay_q = stack_q;
        m_dir = replay_q.pop_front();
        m_move = 1; m_done = 0; m_mode = M_REP;
      end else begin
        m_done = 1; m_mode = M_DONE;
      end
    end else begin
      m_done = 0;
      if (m_mode == M_REC) begin
        if (push && pop && stack_q.size() > 0) stack_q[stack_q.size()-1] = int'(dir);
        else if (push) begin
          if (stack_q.size() < DEPTH) stack_q.push_back(int'(dir));
          else m_ovf = 1;
        end else if (pop && stack_q.size() > 0) void'(stack_q.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_move", move, m_move);
      checkOutput("model_done", done, m_done);
      checkOutput("model_count", count, stack_q.size());
      checkOutput("model_empty", empty, stack_q.size() == 0);
      checkOutput("model_full", full, stack_q.size() == DEPTH);
      checkOutput("model_overflow", overflow, m_ovf);
      if (m_move != 0) checkOutput("model_move_dir", move_dir, m_dir);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; push = 0; pop = 0; dir = 0; run = 0; clear = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_move", move, 0);
    checkOutput("rst_move_dir", move_dir, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;
    check_en = 1'b1;

    $display("[TB] basic record and replay");
    applyStimulus(1, 0, 2'd0, 0, 0);
    applyStimulus(1, 0, 2'd1, 0, 0);
    applyStimulus(1, 0, 2'd2, 0, 0);
    applyStimulus(0, 1, 2'd0, 0, 0);
    applyStimulus(1, 0, 2'd3, 0, 0);
    checkOutput("basic_count", count, 3);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("basic_mv0", move, 1); checkOutput("basic_dir0", move_dir, 0);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("basic_mv1", move, 1); checkOutput("basic_dir1", move_dir, 1);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("basic_mv2", move, 1); checkOutput("basic_dir2", move_dir, 3);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("basic_end_move", move, 0); checkOutput("basic_done", done, 1);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("basic_done_clr", done, 0);

    $display("[TB] empty pop and replace");
    applyStimulus(0, 0, 2'd0, 0, 1);
    applyStimulus(0, 1, 2'd0, 0, 0);
    checkOutput("pop_empty_count", count, 0); checkOutput("pop_empty_empty", empty, 1);
    applyStimulus(1, 0, 2'd2, 0, 0);
    applyStimulus(1, 1, 2'd1, 0, 0);
    checkOutput("replace_count", count, 1);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("replace_mv", move, 1); checkOutput("replace_dir", move_dir, 1);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("replace_end", move, 0); checkOutput("replace_done", done, 1);

    $display("[TB] run with empty stack");
    applyStimulus(0, 0, 2'd0, 0, 1);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("erun_done", done, 1); checkOutput("erun_move", move, 0);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("erun_done_clr", done, 0);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("erun2_done", done, 1); checkOutput("erun2_move", move, 0);

    $display("[TB] overflow then clear mid-replay");
    applyStimulus(0, 0, 2'd0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 2'((i + 1) % 4), 0, 0);
    checkOutput("ovf_full", full, 1); checkOutput("ovf_count", count, DEPTH);
    checkOutput("ovf_flag", overflow, 1);
    applyStimulus(0, 1, 2'd0, 0, 0);
    applyStimulus(0, 1, 2'd0, 0, 0);
    checkOutput("six_count", count, 6); checkOutput("six_ovf_sticky", overflow, 1);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("cm_dir0", move_dir, 1);
    applyStimulus(0, 0, 2'd0, 0, 0);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("cm_dir2", move_dir, 3); checkOutput("cm_mv2", move, 1);
    applyStimulus(0, 0, 2'd0, 0, 1);
    checkOutput("cm_move", move, 0); checkOutput("cm_done", done, 0);
    checkOutput("cm_count", count, 0); checkOutput("cm_ovf", overflow, 0);
    applyStimulus(1, 0, 2'd2, 0, 0);
    checkOutput("cm_push", count, 1);

    $display("[TB] full stack replay");
    applyStimulus(0, 0, 2'd0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 2'((i + 1) % 4), 0, 0);
    applyStimulus(0, 0, 2'd0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("full_mv", move, 1);
      checkOutput("full_dir", move_dir, (i + 1) % 4);
      applyStimulus(0, 0, 2'd0, 0, 0);
    end
    checkOutput("full_done", done, 1);

    $display("[TB] async reset mid-replay");
    applyStimulus(0, 0, 2'd0, 0, 1);
    applyStimulus(1, 0, 2'd3, 0, 0);
    applyStimulus(1, 0, 2'd0, 0, 0);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("ar_pre_move", move, 1);
    rst = 1'b1;
    #1;
    checkOutput("ar_move", move, 0); checkOutput("ar_done", done, 0);
    checkOutput("ar_count", count, 0);
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
    applyStimulus(1, 0, 2'd2, 0, 0);
    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("ar_re_move", move, 1); checkOutput("ar_re_dir", move_dir, 2);
    applyStimulus(0, 0, 2'd0, 0, 0);
    checkOutput("ar_re_done", done, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 63) == 0));

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
